mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 95 +++++++++
 tb/tb_mux_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Round-robin 2:1 burst arbiter; one IDLE cycle per arbitration, bursts capped at MAXBURST beats.
// Output beat registered 1 cycle after accept; ready is held low while an output beat is stalled.
module mux_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAXBURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [3:0]       cnt;
    logic             can_load;
    logic             acc0;
    logic             acc1;
    logic             acc;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;
    logic             burst_end;

    // Output register can take a new beat when empty or draining this cycle.
    always_comb begin
        can_load   = !out_valid || out_ready;
        req0_ready = (state == GRANT0) && can_load;
        req1_ready = (state == GRANT1) && can_load;
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
        acc        = acc0 || acc1;
        acc_last   = acc1 ? req1_last : req0_last;
        acc_data   = acc1 ? req1_data : req0_data;
        burst_end  = acc && (acc_last || (cnt == 4'(MAXBURST - 1)));
        sel        = (state == GRANT1);
        busy       = (state == GRANT0) || (state == GRANT1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (req0_valid && req1_valid)
                        state <= last_grant ? GRANT0 : GRANT1;
                    else if (req0_valid)
                        state <= GRANT0;
                    else if (req1_valid)
                        state <= GRANT1;
                end
                GRANT0, GRANT1: begin
                    if (burst_end) begin
                        state      <= IDLE;
                        last_grant <= (state == GRANT1);
                        cnt        <= 4'd0;
                    end else if (acc) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (acc) begin
                out_valid <= 1'b1;
                out_data  <= acc_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: single grant, round-robin ties, burst cap, stall and async reset.
module tb_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_last, req0_ready;
    logic        req1_valid, req1_last, req1_ready;
    logic [31:0] req0_data, req1_data, out_data;
    logic        out_valid, out_ready, sel, busy;

    int checks = 0;
    int errors = 0;

    mux_arbiter #(.WIDTH(32), .MAXBURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_last = 0; req0_data = 0;
        req1_valid = 0; req1_last = 0; req1_data = 0;
        out_ready = 1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdy0", 32'(req0_ready), 0);
        chk("rst_rdy1", 32'(req1_ready), 0);
        rst_n = 1'b1;
        tick();

        // Single beat from source 0
        req0_valid = 1; req0_data = 32'hA5; req0_last = 1;
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rdy0", 32'(req0_ready), 0);
        tick();
        chk("g0_busy", 32'(busy), 1);
        chk("g0_sel", 32'(sel), 0);
        chk("g0_rdy0", 32'(req0_ready), 1);
        chk("g0_rdy1", 32'(req1_ready), 0);
        chk("g0_out_valid", 32'(out_valid), 0);
        tick();
        chk("a5_out_valid", 32'(out_valid), 1);
        chk("a5_out_data", out_data, 32'hA5);
        chk("a5_busy", 32'(busy), 0);
        req0_valid = 0;
        tick();
        chk("a5_drain", 32'(out_valid), 0);

        // Reset again so the first tie goes to source 0
        rst_n = 0; #1; rst_n = 1;
        req0_valid = 1; req0_data = 32'h11; req0_last = 1;
        req1_valid = 1; req1_data = 32'h22; req1_last = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_sel", 32'(sel), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_busy", 32'(busy), 1);
            tick();
            chk("rr_data", out_data, (i % 2 == 1) ? 32'h22 : 32'h11);
            chk("rr_out_valid", 32'(out_valid), 1);
            chk("rr_idle", 32'(busy), 0);
        end
        req0_valid = 0;
        req1_valid = 1; req1_last = 0; req1_data = 32'h30;
        tick();
        chk("burst_sel", 32'(sel), 1);

        // Burst capped at 4 beats; source 0 waits, ignored until IDLE
        req0_valid = 1; req0_last = 0; req0_data = 32'h40;
        for (int b = 0; b < 4; b++) begin
            req1_data = 32'h30 + 32'(b);
            #1;
            chk("burst_rdy1", 32'(req1_ready), 1);
            chk("burst_rdy0", 32'(req0_ready), 0);
            tick();
            chk("burst_data", out_data, 32'h30 + 32'(b));
            chk("burst_busy", 32'(busy), (b < 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk("after_burst_sel", 32'(sel), 0);
        chk("after_burst_busy", 32'(busy), 1);
        req1_valid = 0;

        // Output stall inside GRANT0
        out_ready = 0;
        #1;
        chk("stall_rdy_pre", 32'(req0_ready), 1);
        tick();
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_data0", out_data, 32'h40);
        req0_data = 32'h41;
        #1;
        chk("stall_rdy_low", 32'(req0_ready), 0);
        tick();
        chk("stall_hold", out_data, 32'h40);
        chk("stall_busy", 32'(busy), 1);
        out_ready = 1;
        #1;
        chk("stall_resume_rdy", 32'(req0_ready), 1);
        tick();
        chk("resume_data", out_data, 32'h41);
        chk("resume_valid", 32'(out_valid), 1);

        // Asynchronous reset mid-burst with a held beat
        #2;
        rst_n = 0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sel", 32'(sel), 0);
        chk("arst_rdy0", 32'(req0_ready), 0);
        chk("arst_rdy1", 32'(req1_ready), 0);
        #1;
        rst_n = 1;
        req0_valid = 1; req0_last = 1;
        req1_valid = 1; req1_last = 1;
        #1;
        chk("rel_busy", 32'(busy), 0);
        tick();
        chk("rel_tie_sel", 32'(sel), 0);
        chk("rel_tie_busy", 32'(busy), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
